lbdr_input_fifo: RTL and testbench
==================================

# lbdr_input_fifo

Per-input-port flit buffer sitting directly upstream of the LBDR routing stage in each router. It stores incoming flits from the neighbouring router in a circular FIFO and presents the head flit's `flit_id` and `dst_addr` together with `empty` to LBDR. It pops on a read strobe from the downstream allocator/crossbar, returns one credit upstream per popped flit, and optionally checks packet framing.

## Interface
- `DATA_WIDTH`, 32: flit width. Flit layout is fixed:
  - [DATA_WIDTH-1 -: 3] = flit_id (`HEADER`/`PAYLOAD`/`TAIL` from parameters.sv).
  - Header flit [3:0] = dst_addr, [7:4] = src_addr.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in DATA_WIDTH: incoming flit.
- `valid_in` in 1: `rx_data` valid this cycle.
- `rd_en` in 1: pop head flit (from allocator/crossbar).
- `dout` out DATA_WIDTH: head flit (first-word-fall-through).
- `flit_id` out 3: head flit type; to LBDR.
- `dst_addr` out 4: destination of current packet; to LBDR.
- `empty` out 1: FIFO empty; to LBDR.
- `full` out 1: FIFO full.
- `credit_out` out 1: one-cycle credit-return pulse to upstream.
- `err_overflow` out 1: sticky; write attempted while full without a simultaneous pop.
- `err_framing` out 1: sticky framing violation (only with PKT_CHECK_EN).

## Operation
- Storage: `DEPTH` × `DATA_WIDTH` array.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits.
  - `empty` = (count==0); `full` = (count==DEPTH). Both are derived from registered count.
- Write: accepted when `valid_in && (!full || rd_en)`.
  - Stores at wr_ptr; wr_ptr increments.
  - `valid_in && full && !rd_en` drops the flit and sets `err_overflow`.
- Read: accepted when `rd_en && !empty`.
  - rd_ptr increments.
  - `rd_en` while empty is ignored: no pointer change, no credit.
- Simultaneous accepted read and write: count unchanged. This holds when full as well, because the slot freed by the pop is available.
- `dout` = mem[rd_ptr] combinationally. `flit_id` = `dout` type field.
- `dst_addr`:
  - Head is a HEADER: `dout[3:0]`.
  - Otherwise: `dst_hold`, a register loaded with `dout[3:0]` whenever a HEADER is popped.
  - This keeps the destination stable for the payload and tail flits.
- `credit_out`: registered. It is 1 in the cycle after each accepted read, so there is exactly one pulse per popped flit.
- Framing FSM, states IDLE and BODY; evaluated on each accepted write:
  - IDLE + HEADER → BODY.
  - IDLE + PAYLOAD/TAIL → set `err_framing`, stay IDLE.
  - BODY + PAYLOAD → BODY.
  - BODY + TAIL → IDLE.
  - BODY + HEADER → set `err_framing`, stay BODY.
  - Offending flits are still stored; the error is flagged only.
- Reset, asynchronous: pointers, count, and `dst_hold` go to 0; FSM goes to IDLE.
  - Outputs: `empty`=1, `full`=0, `credit_out`=0, `err_overflow`=0, `err_framing`=0.
  - Memory is not cleared. `dout`/`flit_id` are don't-care while `empty`=1.
  - Reset mid-packet discards all stored flits and issues no credits for them.

## Timing
- Write-to-visible latency is 1 cycle: a flit written at edge N gives `empty`=0 and a valid head after edge N. There is no same-cycle bypass.
- LBDR registers ports at the next edge, so header-to-port decision is 2 cycles from write.
- Pop-to-credit latency is 1 cycle. The upstream router's credit counter must be initialised to DEPTH.
- Sticky errors assert in the cycle after the offending edge and hold until `rst`.

## Configuration
- `LBDR_FIFO_PKT_CHECK_EN` defined:
  - Framing FSM and `err_framing` logic are present as above.
- Not defined:
  - FSM is not built. `err_framing` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset then write HEADER(dst=4'hA), PAYLOAD, TAIL on consecutive cycles, no reads:
  - `empty` falls 1 cycle after the first write.
  - `flit_id`=`HEADER`, `dst_addr`=4'hA; count=3.
- Pop all 3 flits with `rd_en`=1:
  - `dst_addr` stays 4'hA for PAYLOAD and TAIL.
  - 3 `credit_out` pulses, each 1 cycle after its pop.
  - `empty`=1 after the third pop.
- Fill to DEPTH=4, then:
  - Write with `rd_en`=0 → `err_overflow`=1, count stays 4.
  - Write with `rd_en`=1 → flit accepted, count stays 4, wrap-around order preserved.
- `rd_en`=1 while empty for 3 cycles → no pointer change, `credit_out` stays 0.
- With PKT_CHECK_EN:
  - PAYLOAD as first flit → `err_framing`=1 next cycle.
  - Without the macro, the same stimulus → `err_framing`=0.
- Assert `rst` mid-packet, asynchronously between edges, with 2 flits stored:
  - Immediately `empty`=1, `full`=0, errors 0.
  - Next HEADER is accepted cleanly from IDLE.

Source files
------------

// File: rtl/lbdr_input_fifo_if.sv
// lbdr_input_fifo_if: flit-in / head-out bundle between a router input port, its LBDR stage and the allocator.
// master: upstream link plus downstream consumer (drives rx_data, valid_in, rd_en).
// slave : the input FIFO (drives dout, flit_id, dst_addr, empty, full, credit_out, err_*).
interface lbdr_input_fifo_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  valid_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic [2:0]            flit_id;
    logic [3:0]            dst_addr;
    logic                  empty;
    logic                  full;
    logic                  credit_out;
    logic                  err_overflow;
    logic                  err_framing;
    modport master (output rx_data, valid_in, rd_en,
                    input  dout, flit_id, dst_addr, empty, full, credit_out, err_overflow, err_framing);
    modport slave  (input  rx_data, valid_in, rd_en,
                    output dout, flit_id, dst_addr, empty, full, credit_out, err_overflow, err_framing);
endinterface

// File: rtl/lbdr_input_fifo.sv
// lbdr_input_fifo: circular first-word-fall-through flit buffer feeding LBDR, with credit return and sticky errors.
// Ports: clk, rst (async active-high), bus (slave): rx_data/valid_in in, rd_en pop, dout/flit_id/dst_addr/empty head view,
// full, credit_out (one pulse per popped flit), err_overflow, err_framing.
// Optional: `define LBDR_FIFO_PKT_CHECK_EN builds the packet framing checker; otherwise err_framing is tied to 0.
module lbdr_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic               clk,
    input logic               rst,
    lbdr_input_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [3:0]            dst_hold;
    logic                  wr_ok, rd_ok, err_ov_r, credit_r;
    assign bus.empty    = count == '0;
    assign bus.full     = count == (AW+1)'(DEPTH);
    // a pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read
    assign wr_ok        = bus.valid_in && (!bus.full || bus.rd_en);
    assign rd_ok        = bus.rd_en && !bus.empty;
    assign bus.dout     = mem[rd_ptr];
    assign bus.flit_id  = bus.dout[DATA_WIDTH-1 -: 3];
    // payload/tail flits carry no address; reuse the one latched when their header left
    assign bus.dst_addr = bus.flit_id == HEADER ? bus.dout[3:0] : dst_hold;
    assign bus.credit_out   = credit_r;
    assign bus.err_overflow = err_ov_r;
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= bus.rx_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dst_hold <= '0;
            credit_r <= 1'b0;
            err_ov_r <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(wr_ok);
            rd_ptr   <= rd_ptr + AW'(rd_ok);
            count    <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
            dst_hold <= rd_ok && bus.flit_id == HEADER ? bus.dout[3:0] : dst_hold;
            credit_r <= rd_ok;
            err_ov_r <= err_ov_r | (bus.valid_in && bus.full && !bus.rd_en);
        end
    end
`ifdef LBDR_FIFO_PKT_CHECK_EN
    typedef enum logic {IDLE, BODY} state_t;
    state_t     state, state_nxt;
    logic [2:0] in_id;
    logic       frame_bad, err_fr_r;
    assign in_id = bus.rx_data[DATA_WIDTH-1 -: 3];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            err_fr_r <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_fr_r <= err_fr_r | frame_bad;
        end
    end
    // offending flits are still stored; the checker only flags them
    always_comb begin
        state_nxt = state;
        frame_bad = 1'b0;
        if (wr_ok && state == IDLE) begin
            state_nxt = in_id == HEADER ? BODY : IDLE;
            frame_bad = in_id == PAYLOAD || in_id == TAIL;
        end else if (wr_ok) begin
            state_nxt = in_id == TAIL ? IDLE : BODY;
            frame_bad = in_id == HEADER;
        end
    end
    assign bus.err_framing = err_fr_r;
`else
    assign bus.err_framing = 1'b0;
`endif
endmodule

// File: tb/tb_lbdr_input_fifo.sv
// tb_lbdr_input_fifo: scoreboard bench for lbdr_input_fifo (DEPTH 4, 32-bit flits), both framing-check builds.
module tb_lbdr_input_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;
`ifdef LBDR_FIFO_PKT_CHECK_EN
    localparam logic EXP_FR = 1'b1;
`else
    localparam logic EXP_FR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    lbdr_input_fifo_if #(.DATA_WIDTH(DW)) bus ();
    lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [DW-1:0] q[$];
    logic          exp_credit = 1'b0;
    int            errors = 0;
    int            checks = 0;

    function automatic logic [DW-1:0] flit(input logic [2:0] id, input logic [3:0] dst, input logic [7:0] tag);
        logic [DW-1:0] f;
        f = '0;
        f[DW-1 -: 3] = id;
        f[15:8] = tag;
        f[7:4]  = 4'h5;
        f[3:0]  = dst;
        return f;
    endfunction

    // one clock of stimulus; the scoreboard queue tracks what the FIFO should hold
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        bit rd_acc, wr_acc;
        bus.valid_in = v;
        bus.rx_data  = d;
        bus.rd_en    = r;
        rd_acc = r && q.size() > 0;
        wr_acc = v && (q.size() < DEPTH || r);
        if (rd_acc) void'(q.pop_front());
        if (wr_acc) q.push_back(d);
        exp_credit = rd_acc;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", bus.full); end
        checks++; if (bus.credit_out !== 1'b0) begin errors++; $display("FAIL rst_credit: got %b want 0", bus.credit_out); end
        checks++; if (bus.err_overflow !== 1'b0 || bus.err_framing !== 1'b0) begin errors++; $display("FAIL rst_err: got %b%b want 00", bus.err_overflow, bus.err_framing); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_rel_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_packet;
        drive(1'b1, flit(HEADER, 4'hA, 8'h01), 1'b0);
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL pkt_empty: got %b want 0", bus.empty); end
        checks++; if (bus.flit_id !== HEADER) begin errors++; $display("FAIL pkt_id: got %b want %b", bus.flit_id, HEADER); end
        checks++; if (bus.dst_addr !== 4'hA) begin errors++; $display("FAIL pkt_dst: got %h want a", bus.dst_addr); end
        drive(1'b1, flit(PAYLOAD, 4'h0, 8'h02), 1'b0);
        drive(1'b1, flit(TAIL, 4'h0, 8'h03), 1'b0);
        checks++; if (bus.full !== 1'b0 || bus.empty !== 1'b0) begin errors++; $display("FAIL pkt_cnt3: full/empty got %b%b want 00", bus.full, bus.empty); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL pkt_dout%0d: got %h want %h", i, bus.dout, q[0]); end
            checks++; if (bus.dst_addr !== 4'hA) begin errors++; $display("FAIL pkt_hold%0d: got %h want a", i, bus.dst_addr); end
            drive(1'b0, '0, 1'b1);
            checks++; if (bus.credit_out !== exp_credit) begin errors++; $display("FAIL pkt_credit%0d: got %b want %b", i, bus.credit_out, exp_credit); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL pkt_drained: got %b want 1", bus.empty); end
        drive(1'b0, '0, 1'b0);
        checks++; if (bus.credit_out !== 1'b0) begin errors++; $display("FAIL pkt_credit_end: got %b want 0", bus.credit_out); end
    endtask

    task automatic test_overflow;
        drive(1'b1, flit(HEADER, 4'h3, 8'h10), 1'b0);
        drive(1'b1, flit(PAYLOAD, 4'h0, 8'h11), 1'b0);
        drive(1'b1, flit(PAYLOAD, 4'h0, 8'h12), 1'b0);
        drive(1'b1, flit(TAIL, 4'h0, 8'h13), 1'b0);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", bus.full); end
        checks++; if (bus.err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", bus.err_overflow); end
        drive(1'b1, flit(PAYLOAD, 4'h0, 8'h20), 1'b0);
        checks++; if (bus.err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.err_overflow); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full2: got %b want 1", bus.full); end
        checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL ovf_head: got %h want %h", bus.dout, q[0]); end
        drive(1'b1, flit(HEADER, 4'h7, 8'h21), 1'b1);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_rw_full: got %b want 1", bus.full); end
        checks++; if (bus.credit_out !== 1'b1) begin errors++; $display("FAIL ovf_rw_credit: got %b want 1", bus.credit_out); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", i, bus.dout, q[0]); end
            drive(1'b0, '0, 1'b1);
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b want 1", bus.empty); end
        checks++; if (bus.err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.err_overflow); end
    endtask

    task automatic test_empty_read;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            checks++; if (bus.credit_out !== 1'b0) begin errors++; $display("FAIL er_credit%0d: got %b want 0", i, bus.credit_out); end
            checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL er_empty%0d: got %b want 1", i, bus.empty); end
        end
        drive(1'b1, flit(TAIL, 4'h0, 8'h30), 1'b0);
        checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL er_head: got %h want %h", bus.dout, q[0]); end
        drive(1'b0, '0, 1'b1);
        checks++; if (bus.credit_out !== 1'b1) begin errors++; $display("FAIL er_credit_pop: got %b want 1", bus.credit_out); end
        checks++; if (bus.err_framing !== 1'b0) begin errors++; $display("FAIL er_framing: got %b want 0", bus.err_framing); end
    endtask

    task automatic test_framing;
        drive(1'b1, flit(PAYLOAD, 4'h0, 8'h40), 1'b0);
        checks++; if (bus.err_framing !== EXP_FR) begin errors++; $display("FAIL fr_flag: got %b want %b", bus.err_framing, EXP_FR); end
        checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL fr_stored: got %h want %h", bus.dout, q[0]); end
        drive(1'b0, '0, 1'b1);
        checks++; if (bus.err_framing !== EXP_FR) begin errors++; $display("FAIL fr_sticky: got %b want %b", bus.err_framing, EXP_FR); end
    endtask

    task automatic test_async_reset;
        drive(1'b1, flit(HEADER, 4'h5, 8'h50), 1'b0);
        drive(1'b1, flit(PAYLOAD, 4'h0, 8'h51), 1'b0);
        drive(1'b1, flit(PAYLOAD, 4'h0, 8'h52), 1'b0);
        drive(1'b0, '0, 1'b1);
        checks++; if (bus.empty !== 1'b0 || bus.credit_out !== 1'b1) begin errors++; $display("FAIL ar_pre: empty/credit got %b%b want 01", bus.empty, bus.credit_out); end
        #2 rst = 1'b1;
        #1;
        q.delete();
        exp_credit = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ar_empty: got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL ar_full: got %b want 0", bus.full); end
        checks++; if (bus.credit_out !== 1'b0) begin errors++; $display("FAIL ar_credit: got %b want 0", bus.credit_out); end
        checks++; if (bus.err_overflow !== 1'b0 || bus.err_framing !== 1'b0) begin errors++; $display("FAIL ar_err: got %b%b want 00", bus.err_overflow, bus.err_framing); end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, flit(HEADER, 4'h3, 8'h60), 1'b0);
        checks++; if (bus.flit_id !== HEADER || bus.dst_addr !== 4'h3) begin errors++; $display("FAIL ar_hdr: id/dst got %b/%h want %b/3", bus.flit_id, bus.dst_addr, HEADER); end
        checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL ar_head: got %h want %h", bus.dout, q[0]); end
        drive(1'b1, flit(TAIL, 4'h0, 8'h61), 1'b0);
        checks++; if (bus.err_framing !== 1'b0) begin errors++; $display("FAIL ar_framing: got %b want 0", bus.err_framing); end
        drive(1'b0, '0, 1'b1);
        checks++; if (bus.dout !== q[0] || bus.dst_addr !== 4'h3) begin errors++; $display("FAIL ar_tail: dout/dst got %h/%h want %h/3", bus.dout, bus.dst_addr, q[0]); end
        drive(1'b0, '0, 1'b1);
        checks++; if (bus.empty !== 1'b1 || bus.credit_out !== 1'b1) begin errors++; $display("FAIL ar_end: empty/credit got %b%b want 11", bus.empty, bus.credit_out); end
    endtask

    initial begin
        bus.rx_data  = '0;
        bus.valid_in = 1'b0;
        bus.rd_en    = 1'b0;
        test_reset();
        test_packet();
        test_overflow();
        test_empty_read();
        test_framing();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
